cache_miss_ctrl: RTL and testbench
==================================

CACHE_MISS_CTRL -- requirements
Module: cache_miss_ctrl

Interface
REQ-001 SHALL have parameter AWIDTH, default 6: set-index width (64 sets).
REQ-002 SHALL have parameter TWIDTH, default 6: tag width.
REQ-003 SHALL have parameter WWIDTH, default 3: way-index width (8 ways); maximum victim value is 7.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port req_valid  input  1  lookup request present.
REQ-007 SHALL have port req_ready  output  1  controller can accept a request (high only in IDLE).
REQ-008 SHALL have port req_addr  input  TWIDTH+AWIDTH  {tag, set index}; index = low AWIDTH bits.
REQ-009 SHALL have port resp_valid  output  1  lookup result available.
REQ-010 SHALL have port resp_ready  input  1  consumer accepts the result.
REQ-011 SHALL have port resp_hit  output  1  1 = hit, 0 = result after refill.
REQ-012 SHALL have port resp_way  output  WWIDTH  way holding the line.
REQ-013 SHALL have port mem_rd_valid  output  1  refill read request.
REQ-014 SHALL have port mem_rd_ready  input  1  memory accepts the read.
REQ-015 SHALL have port mem_rd_addr  output  TWIDTH+AWIDTH  line address to fetch.
REQ-016 SHALL have port mem_rsp_valid  input  1  refill data present this cycle.
REQ-017 SHALL have port fill_we  output  1  data-array write strobe.
REQ-018 SHALL have port fill_set  output  AWIDTH  data-array set for the fill.
REQ-019 SHALL have port fill_way  output  WWIDTH  data-array way for the fill.

Function
REQ-020 SHALL hold per set and way a valid bit and a TWIDTH tag, plus one WWIDTH round-robin victim pointer per set.
REQ-021 SHALL implement the FSM IDLE, LOOKUP, MISS_REQ, MISS_WAIT, FILL, RESP.
REQ-022 IDLE: req_ready=1; on req_valid, SHALL latch req_addr and go to LOOKUP.
REQ-023 LOOKUP: SHALL compare the latched tag against all valid ways of the latched set in one cycle. On a hit, SHALL record the way and go to RESP with resp_hit=1. On a miss, SHALL go to MISS_REQ.
REQ-024 A hit SHALL assert resp_valid exactly 2 cycles after the accepting edge.
REQ-025 MISS_REQ: SHALL hold mem_rd_valid=1 and mem_rd_addr = latched address until mem_rd_ready=1, then go to MISS_WAIT.
REQ-026 MISS_WAIT: SHALL wait any number of cycles for mem_rsp_valid=1, then go to FILL. mem_rsp_valid outside MISS_WAIT SHALL be ignored.
REQ-027 Victim way SHALL be the set's pointer value, captured on entry to MISS_REQ.
REQ-028 FILL: SHALL assert fill_we for exactly one cycle with fill_set and fill_way. In the same cycle it SHALL set valid=1 and tag for that way, and advance the set's pointer (7 wraps to 0). It SHALL then go to RESP with resp_hit=0 and resp_way=victim.
REQ-029 Pointers SHALL advance only in FILL, never on hits.
REQ-030 RESP: resp_valid, resp_hit and resp_way SHALL be held stable until resp_ready=1, then go to IDLE. No new request SHALL be accepted in that cycle.
REQ-031 mem_rd_valid, fill_we and resp_valid SHALL each be high only in their own state and SHALL be registered outputs.
REQ-032 A request to the set being filled SHALL see the new line, because it can only be accepted after RESP.

Reset
REQ-033 Reset SHALL force IDLE, clear all valid bits and all pointers to 0, and drive resp_valid, mem_rd_valid and fill_we to 0. resp_hit, resp_way, fill_set and fill_way SHALL be 0.
REQ-034 Reset asserted mid-miss SHALL abandon the refill. mem_rd_valid SHALL drop asynchronously, and no fill SHALL follow.

Structure
REQ-035 A shared package SHALL hold the FSM state enum and the AWIDTH/TWIDTH/WWIDTH defaults.
REQ-036 Victim pointers SHALL be a sub-module repl_ptr (per-set pointer array, advance strobe, set index in, pointer out).

Verification
REQ-037 Reset, then req_addr={tag 5, set 3} -> miss; mem_rd_addr=0x143; after mem_rsp_valid: fill_we with set 3, way 0; resp_hit=0, resp_way=0.
REQ-038 Repeat the same address -> resp_hit=1, resp_way=0, resp_valid 2 cycles after acceptance, no mem_rd_valid.
REQ-039 Nine distinct-tag misses to set 3 -> fill_way sequence 0..7,0; the ninth fill evicts tag of the first fill (its re-request misses).
REQ-040 Hold mem_rd_ready=0 for 5 cycles -> mem_rd_valid/addr stable; hold resp_ready=0 for 4 cycles -> resp fields stable.
REQ-041 Assert reset in MISS_WAIT -> IDLE, all outputs 0; later mem_rsp_valid -> no fill_we; the same address misses again.
REQ-042 Misses to set 3 and set 4 in turn -> each set's pointer advances independently (way 0 in both).

Source files
------------

// File: rtl/cache_miss_ctrl_pkg.sv
// Shared definitions for the cache miss controller: default geometry and FSM encoding.
package cache_miss_ctrl_pkg;

  localparam int AWIDTH_DEF = 6;
  localparam int TWIDTH_DEF = 6;
  localparam int WWIDTH_DEF = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_MISS_REQ,
    ST_MISS_WAIT,
    ST_FILL,
    ST_RESP
  } state_e;

endpackage

// File: rtl/cache_miss_ctrl_if.sv
// Request, response, refill-read and fill-strobe signals of the miss controller.
interface cache_miss_ctrl_if import cache_miss_ctrl_pkg::*; #(
  parameter int AWIDTH = AWIDTH_DEF,
  parameter int TWIDTH = TWIDTH_DEF,
  parameter int WWIDTH = WWIDTH_DEF
);

  logic                     req_valid;
  logic                     req_ready;
  logic [TWIDTH+AWIDTH-1:0] req_addr;

  logic                     resp_valid;
  logic                     resp_ready;
  logic                     resp_hit;
  logic [WWIDTH-1:0]        resp_way;

  logic                     mem_rd_valid;
  logic                     mem_rd_ready;
  logic [TWIDTH+AWIDTH-1:0] mem_rd_addr;
  logic                     mem_rsp_valid;

  logic                     fill_we;
  logic [AWIDTH-1:0]        fill_set;
  logic [WWIDTH-1:0]        fill_way;

  // Controller side
  modport slave (
    input  req_valid, req_addr, resp_ready, mem_rd_ready, mem_rsp_valid,
    output req_ready, resp_valid, resp_hit, resp_way,
    output mem_rd_valid, mem_rd_addr, fill_we, fill_set, fill_way
  );

  // Requester / memory side
  modport master (
    output req_valid, req_addr, resp_ready, mem_rd_ready, mem_rsp_valid,
    input  req_ready, resp_valid, resp_hit, resp_way,
    input  mem_rd_valid, mem_rd_addr, fill_we, fill_set, fill_way
  );

endinterface

// File: rtl/cache_miss_ctrl_repl_ptr.sv
// Per-set round-robin victim pointers; the addressed pointer steps by one on i_adv.
module repl_ptr import cache_miss_ctrl_pkg::*; #(
  parameter int AWIDTH = AWIDTH_DEF,
  parameter int WWIDTH = WWIDTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_adv,
  input  logic [AWIDTH-1:0] i_set,
  output logic [WWIDTH-1:0] o_ptr
);

  localparam int SETS = 1 << AWIDTH;

  logic [WWIDTH-1:0] r_ptr [SETS];

  // Natural WWIDTH-bit overflow gives the wrap from the last way back to 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++) begin
        r_ptr[s] <= '0;
      end
    end else if (i_adv) begin
      r_ptr[i_set] <= r_ptr[i_set] + WWIDTH'(1);
    end
  end

  assign o_ptr = r_ptr[i_set];

endmodule

// File: rtl/cache_miss_ctrl.sv
// Set-associative tag/valid store with a blocking miss FSM: lookup, refill read, fill, respond.
module cache_miss_ctrl import cache_miss_ctrl_pkg::*; #(
  parameter int AWIDTH = AWIDTH_DEF,
  parameter int TWIDTH = TWIDTH_DEF,
  parameter int WWIDTH = WWIDTH_DEF
) (
  input  logic               clk,
  input  logic               reset,
  cache_miss_ctrl_if.slave   bus
);

  localparam int SETS = 1 << AWIDTH;
  localparam int WAYS = 1 << WWIDTH;
  localparam int LW   = TWIDTH + AWIDTH;

  state_e              r_state;
  logic [LW-1:0]       r_addr;
  logic [WWIDTH-1:0]   r_victim;
  logic                r_req_ready;
  logic                r_resp_valid;
  logic                r_resp_hit;
  logic [WWIDTH-1:0]   r_resp_way;
  logic                r_mem_rd_valid;
  logic [LW-1:0]       r_mem_rd_addr;
  logic                r_fill_we;
  logic [AWIDTH-1:0]   r_fill_set;
  logic [WWIDTH-1:0]   r_fill_way;

  logic [WAYS-1:0]     r_valid [SETS];
  logic [TWIDTH-1:0]   r_tag   [SETS][WAYS];

  logic [AWIDTH-1:0]   w_set;
  logic [TWIDTH-1:0]   w_tag;
  logic                w_hit;
  logic [WWIDTH-1:0]   w_hit_way;
  logic [WWIDTH-1:0]   w_ptr;
  logic                w_fill_commit;

  assign w_set         = r_addr[AWIDTH-1:0];
  assign w_tag         = r_addr[AWIDTH +: TWIDTH];
  assign w_fill_commit = (r_state == ST_FILL);

  repl_ptr #(
    .AWIDTH (AWIDTH),
    .WWIDTH (WWIDTH)
  ) u_repl_ptr (
    .clk   (clk),
    .reset (reset),
    .i_adv (w_fill_commit),
    .i_set (w_set),
    .o_ptr (w_ptr)
  );

  // Parallel compare of the latched tag against every valid way of the latched set.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!w_hit && r_valid[w_set][w] && (r_tag[w_set][w] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WWIDTH'(w);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
      end
    end else if (w_fill_commit) begin
      r_valid[w_set][r_victim] <= 1'b1;
    end
  end

  // Tag contents are meaningless while the valid bit is clear, so they carry no reset.
  always_ff @(posedge clk) begin
    if (w_fill_commit) begin
      r_tag[w_set][r_victim] <= w_tag;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_addr         <= '0;
      r_victim       <= '0;
      r_req_ready    <= 1'b1;
      r_resp_valid   <= 1'b0;
      r_resp_hit     <= 1'b0;
      r_resp_way     <= '0;
      r_mem_rd_valid <= 1'b0;
      r_mem_rd_addr  <= '0;
      r_fill_we      <= 1'b0;
      r_fill_set     <= '0;
      r_fill_way     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            r_addr      <= bus.req_addr;
            r_req_ready <= 1'b0;
            r_state     <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (w_hit) begin
            r_resp_valid <= 1'b1;
            r_resp_hit   <= 1'b1;
            r_resp_way   <= w_hit_way;
            r_state      <= ST_RESP;
          end else begin
            r_victim       <= w_ptr;
            r_mem_rd_valid <= 1'b1;
            r_mem_rd_addr  <= r_addr;
            r_state        <= ST_MISS_REQ;
          end
        end
        ST_MISS_REQ: begin
          if (bus.mem_rd_ready) begin
            r_mem_rd_valid <= 1'b0;
            r_state        <= ST_MISS_WAIT;
          end
        end
        ST_MISS_WAIT: begin
          if (bus.mem_rsp_valid) begin
            r_fill_we  <= 1'b1;
            r_fill_set <= w_set;
            r_fill_way <= r_victim;
            r_state    <= ST_FILL;
          end
        end
        ST_FILL: begin
          r_fill_we    <= 1'b0;
          r_resp_valid <= 1'b1;
          r_resp_hit   <= 1'b0;
          r_resp_way   <= r_victim;
          r_state      <= ST_RESP;
        end
        ST_RESP: begin
          // Return to IDLE with req_ready rising only after this edge, so no same-cycle accept.
          if (bus.resp_ready) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready    = r_req_ready;
  assign bus.resp_valid   = r_resp_valid;
  assign bus.resp_hit     = r_resp_hit;
  assign bus.resp_way     = r_resp_way;
  assign bus.mem_rd_valid = r_mem_rd_valid;
  assign bus.mem_rd_addr  = r_mem_rd_addr;
  assign bus.fill_we      = r_fill_we;
  assign bus.fill_set     = r_fill_set;
  assign bus.fill_way     = r_fill_way;

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Bench for cache_miss_ctrl: vector table of lookups plus reset-during-miss sequences.
module tb_cache_miss_ctrl;

  localparam int AW = 12;

  typedef struct {
    logic [AW-1:0] addr;
    bit            hit;
    logic [2:0]    way;
    int            rd_stall;
    int            rsp_lat;
    int            resp_stall;
  } vec_t;

  typedef struct packed {
    logic       hit;
    logic [2:0] way;
  } resp_t;

  typedef struct packed {
    logic [5:0] set;
    logic [2:0] way;
  } fill_t;

  localparam int NV = 18;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cur_vec = -1;

  resp_t         exp_resp_q[$];
  logic [AW-1:0] exp_mem_q[$];
  fill_t         exp_fill_q[$];
  vec_t          vecs[NV];

  resp_t         m_resp;
  fill_t         m_fill;
  logic [AW-1:0] m_addr;

  cache_miss_ctrl_if bus ();

  cache_miss_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (vec %0d): got %0h required %0h", name, cur_vec, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Scoreboard: handshakes and fill strobes pop what the stimulus pushed.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.mem_rd_valid && bus.mem_rd_ready) begin
        if (exp_mem_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL mem_rd_unexpected (vec %0d): got addr %0h required none", cur_vec, bus.mem_rd_addr);
        end else begin
          m_addr = exp_mem_q.pop_front();
          chk("mem_rd_addr", 32'(bus.mem_rd_addr), 32'(m_addr));
        end
      end
      if (bus.fill_we) begin
        if (exp_fill_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL fill_unexpected (vec %0d): got set %0d way %0d required none", cur_vec, bus.fill_set, bus.fill_way);
        end else begin
          m_fill = exp_fill_q.pop_front();
          chk("fill_set", 32'(bus.fill_set), 32'(m_fill.set));
          chk("fill_way", 32'(bus.fill_way), 32'(m_fill.way));
        end
      end
      if (bus.resp_valid && bus.resp_ready) begin
        if (exp_resp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL resp_unexpected (vec %0d): got hit %0d way %0d required none", cur_vec, bus.resp_hit, bus.resp_way);
        end else begin
          m_resp = exp_resp_q.pop_front();
          chk("resp_hit", 32'(bus.resp_hit), 32'(m_resp.hit));
          chk("resp_way", 32'(bus.resp_way), 32'(m_resp.way));
        end
      end
    end
  end

  task automatic run_req(input logic [AW-1:0] addr, input bit hit, input logic [2:0] way,
                         input int rd_stall, input int rsp_lat, input int resp_stall);
    int n;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 20) begin step(); n++; end
    chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
    exp_resp_q.push_back('{hit: hit, way: way});
    if (!hit) begin
      exp_mem_q.push_back(addr);
      exp_fill_q.push_back('{set: addr[5:0], way: way});
    end
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    step();
    bus.req_valid = 1'b0;
    chk("req_ready_busy", 32'(bus.req_ready), 32'd0);
    if (hit) begin
      chk("hit_resp_early", 32'(bus.resp_valid), 32'd0);
      step();
      chk("hit_resp_valid", 32'(bus.resp_valid), 32'd1);
      chk("hit_no_mem_rd", 32'(bus.mem_rd_valid), 32'd0);
    end else begin
      n = 0;
      while (bus.mem_rd_valid !== 1'b1 && n < 10) begin step(); n++; end
      chk("mem_rd_valid_seen", 32'(bus.mem_rd_valid), 32'd1);
      for (int i = 0; i < rd_stall; i++) begin
        step();
        chk("mem_rd_valid_hold", 32'(bus.mem_rd_valid), 32'd1);
        chk("mem_rd_addr_hold", 32'(bus.mem_rd_addr), 32'(addr));
      end
      bus.mem_rd_ready = 1'b1;
      step();
      bus.mem_rd_ready = 1'b0;
      for (int i = 0; i < rsp_lat; i++) step();
      bus.mem_rsp_valid = 1'b1;
      step();
      bus.mem_rsp_valid = 1'b0;
    end
    n = 0;
    while (bus.resp_valid !== 1'b1 && n < 10) begin step(); n++; end
    chk("resp_valid_seen", 32'(bus.resp_valid), 32'd1);
    for (int i = 0; i < resp_stall; i++) begin
      step();
      chk("resp_valid_hold", 32'(bus.resp_valid), 32'd1);
      chk("resp_hit_hold", 32'(bus.resp_hit), 32'(hit));
      chk("resp_way_hold", 32'(bus.resp_way), 32'(way));
    end
    bus.resp_ready = 1'b1;
    step();
    bus.resp_ready = 1'b0;
    chk("resp_valid_drop", 32'(bus.resp_valid), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_resp_valid"},   32'(bus.resp_valid),   32'd0);
    chk({tag, "_mem_rd_valid"}, 32'(bus.mem_rd_valid), 32'd0);
    chk({tag, "_fill_we"},      32'(bus.fill_we),      32'd0);
    chk({tag, "_resp_hit"},     32'(bus.resp_hit),     32'd0);
    chk({tag, "_resp_way"},     32'(bus.resp_way),     32'd0);
    chk({tag, "_fill_set"},     32'(bus.fill_set),     32'd0);
    chk({tag, "_fill_way"},     32'(bus.fill_way),     32'd0);
  endtask

  initial begin
    int n;
    // addr = {tag, set}: tag*64 + set
    vecs[0]  = '{12'h143, 1'b0, 3'd0, 0, 2, 0};
    vecs[1]  = '{12'h143, 1'b1, 3'd0, 0, 0, 4};
    vecs[2]  = '{12'h183, 1'b0, 3'd1, 5, 1, 4};
    vecs[3]  = '{12'h1C3, 1'b0, 3'd2, 0, 0, 0};
    vecs[4]  = '{12'h203, 1'b0, 3'd3, 1, 3, 0};
    vecs[5]  = '{12'h243, 1'b0, 3'd4, 0, 0, 1};
    vecs[6]  = '{12'h283, 1'b0, 3'd5, 2, 0, 0};
    vecs[7]  = '{12'h2C3, 1'b0, 3'd6, 0, 4, 0};
    vecs[8]  = '{12'h303, 1'b0, 3'd7, 0, 0, 0};
    vecs[9]  = '{12'h343, 1'b0, 3'd0, 0, 1, 0};
    vecs[10] = '{12'h143, 1'b0, 3'd1, 0, 0, 0};
    vecs[11] = '{12'h1C3, 1'b1, 3'd2, 0, 0, 0};
    vecs[12] = '{12'h343, 1'b1, 3'd0, 0, 0, 2};
    vecs[13] = '{12'h144, 1'b0, 3'd0, 0, 0, 0};
    vecs[14] = '{12'h503, 1'b0, 3'd2, 0, 0, 0};
    vecs[15] = '{12'h184, 1'b0, 3'd1, 0, 2, 0};
    vecs[16] = '{12'h144, 1'b1, 3'd0, 0, 0, 0};
    vecs[17] = '{12'h183, 1'b0, 3'd3, 0, 0, 0};

    bus.req_valid     = 1'b0;
    bus.req_addr      = '0;
    bus.resp_ready    = 1'b0;
    bus.mem_rd_ready  = 1'b0;
    bus.mem_rsp_valid = 1'b0;

    repeat (3) step();
    chk_reset_outputs("rst");
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    reset = 1'b0;
    step();

    for (int i = 0; i < NV; i++) begin
      cur_vec = i;
      run_req(vecs[i].addr, vecs[i].hit, vecs[i].way,
              vecs[i].rd_stall, vecs[i].rsp_lat, vecs[i].resp_stall);
    end

    // Reset while the refill read is outstanding: mem_rd_valid must fall before any edge.
    cur_vec = 100;
    bus.req_valid = 1'b1;
    bus.req_addr  = 12'h0C5;
    step();
    bus.req_valid = 1'b0;
    n = 0;
    while (bus.mem_rd_valid !== 1'b1 && n < 10) begin step(); n++; end
    chk("A_mem_rd_valid_up", 32'(bus.mem_rd_valid), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk_reset_outputs("A");
    chk("A_req_ready", 32'(bus.req_ready), 32'd1);
    step();
    reset = 1'b0;
    step();

    // Reset in MISS_WAIT, then a late refill response that must not fill.
    cur_vec = 101;
    bus.req_valid = 1'b1;
    bus.req_addr  = 12'h0C5;
    step();
    bus.req_valid = 1'b0;
    n = 0;
    while (bus.mem_rd_valid !== 1'b1 && n < 10) begin step(); n++; end
    exp_mem_q.push_back(12'h0C5);
    bus.mem_rd_ready = 1'b1;
    step();
    bus.mem_rd_ready = 1'b0;
    step();
    chk("B_mem_rd_valid_low", 32'(bus.mem_rd_valid), 32'd0);
    chk("B_fill_we_low", 32'(bus.fill_we), 32'd0);
    #1 reset = 1'b1;
    #1;
    chk_reset_outputs("B");
    step();
    reset = 1'b0;
    bus.mem_rsp_valid = 1'b1;
    step();
    bus.mem_rsp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("B_no_fill", 32'(bus.fill_we), 32'd0);
      chk("B_idle", 32'(bus.req_ready), 32'd1);
    end

    cur_vec = 102;
    run_req(12'h0C5, 1'b0, 3'd0, 0, 1, 0);
    cur_vec = 103;
    run_req(12'h143, 1'b0, 3'd0, 0, 0, 0);
    cur_vec = 104;
    run_req(12'h0C5, 1'b1, 3'd0, 0, 0, 0);

    repeat (2) step();
    chk("resp_q_drained", 32'(exp_resp_q.size()), 32'd0);
    chk("mem_q_drained",  32'(exp_mem_q.size()),  32'd0);
    chk("fill_q_drained", 32'(exp_fill_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
